modbus_req_ctrl: RTL and testbench

//  Sequences one received Modbus RTU request end to end. Hands the decoded fields to the

---
 rtl/modbus_pkg.sv | 48 ++++
 rtl/modbus_req_ctrl_if.sv | 46 ++++
 rtl/modbus_tx_seq.sv | 105 ++++++++++
 rtl/modbus_req_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_modbus_req_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/modbus_pkg.sv
// Shared definitions for the Modbus RTU request controller.
//   - function codes handled by the controller
//   - exception codes returned by the checker
//   - state encodings and the FSM state type
//   - TX frame kinds selected by the byte sequencer
package modbus_pkg;

  localparam logic [7:0] FC_RD_HOLD   = 8'h03;
  localparam logic [7:0] FC_RD_IN     = 8'h04;
  localparam logic [7:0] FC_WR_SINGLE = 8'h06;

  localparam logic [7:0] EXC_NONE     = 8'h00;
  localparam logic [7:0] EXC_ILL_FUNC = 8'h01;
  localparam logic [7:0] EXC_ILL_ADDR = 8'h02;
  localparam logic [7:0] EXC_ILL_QTY  = 8'h03;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CHECK   = 3'd1;
  localparam logic [2:0] ST_EXC_TX  = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_WAIT = 3'd4;
  localparam logic [2:0] ST_RD_TX   = 3'd5;
  localparam logic [2:0] ST_WR      = 3'd6;
  localparam logic [2:0] ST_ECHO_TX = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_CHECK   = ST_CHECK,
    S_EXC_TX  = ST_EXC_TX,
    S_RD_REQ  = ST_RD_REQ,
    S_RD_WAIT = ST_RD_WAIT,
    S_RD_TX   = ST_RD_TX,
    S_WR      = ST_WR,
    S_ECHO_TX = ST_ECHO_TX
  } state_e;

  typedef enum logic [1:0] {
    TXK_EXC  = 2'd0,
    TXK_RD   = 2'd1,
    TXK_ECHO = 2'd2
  } tx_kind_e;

  // Read response byte count: two bytes per register.
  function automatic logic [7:0] byte_count(input logic [6:0] qty);
    return {qty, 1'b0};
  endfunction

endpackage

// File: rtl/modbus_req_ctrl_if.sv
// Bus bundle between the request controller and its neighbours
// (RX parser, exception checker, register file, TX frame builder).
//   slave  : used by modbus_req_ctrl
//   master : used by the environment driving requests / verdicts / tx_ready
interface modbus_req_ctrl_if;
  logic        rx_done;
  logic [7:0]  rx_slave;
  logic [7:0]  rx_func;
  logic [15:0] rx_addr;
  logic [15:0] rx_data;
  logic        busy;
  logic        chk_req;
  logic [7:0]  chk_func;
  logic [15:0] chk_addr;
  logic [15:0] chk_data;
  logic        chk_done;
  logic [7:0]  chk_code;
  logic        reg_rd_en;
  logic [15:0] reg_rd_addr;
  logic [15:0] reg_rd_data;
  logic        reg_wr_en;
  logic [15:0] reg_wr_addr;
  logic [15:0] reg_wr_data;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_last;
  logic        tx_ready;
  logic        frame_drop;
  logic        chk_timeout;

  modport slave (
    input  rx_done, rx_slave, rx_func, rx_addr, rx_data,
    input  chk_done, chk_code, reg_rd_data, tx_ready,
    output busy, chk_req, chk_func, chk_addr, chk_data,
    output reg_rd_en, reg_rd_addr, reg_wr_en, reg_wr_addr, reg_wr_data,
    output tx_valid, tx_byte, tx_last, frame_drop, chk_timeout
  );

  modport master (
    output rx_done, rx_slave, rx_func, rx_addr, rx_data,
    output chk_done, chk_code, reg_rd_data, tx_ready,
    input  busy, chk_req, chk_func, chk_addr, chk_data,
    input  reg_rd_en, reg_rd_addr, reg_wr_en, reg_wr_addr, reg_wr_data,
    input  tx_valid, tx_byte, tx_last, frame_drop, chk_timeout
  );
endinterface

// File: rtl/modbus_tx_seq.sv
// Payload byte sequencer. Selects the byte for (kind, idx) and holds it on
// tx_byte/tx_last with tx_valid until the builder takes it.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   load_i            present byte idx_i of frame kind_i (ignored while a byte is pending)
//   kind_i, idx_i     frame kind and byte index chosen by the FSM
//   last_i            byte being loaded is the final one of the frame
//   func_i..rdat_i    latched request fields / verdict / captured read data
//   tx_ready_i        builder ready
//   tx_valid_o, tx_byte_o, tx_last_o  payload stream
//   acc_o             byte accepted this cycle (valid && ready)
module modbus_tx_seq
  import modbus_pkg::*;
#(
  parameter logic [7:0] SLAVE_ADDR = 8'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  tx_kind_e    kind_i,
  input  logic [2:0]  idx_i,
  input  logic        last_i,
  input  logic [7:0]  func_i,
  input  logic [7:0]  code_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] data_i,
  input  logic [15:0] rdat_i,
  input  logic        tx_ready_i,
  output logic        tx_valid_o,
  output logic [7:0]  tx_byte_o,
  output logic        tx_last_o,
  output logic        acc_o
);

  logic       vld_q, vld_d;
  logic       last_q, last_d;
  logic [7:0] byte_q, byte_d;
  logic [7:0] sel;

  always_comb begin
    sel = SLAVE_ADDR;
    unique case (kind_i)
      TXK_EXC: begin
        case (idx_i)
          3'd1:    sel = func_i | 8'h80;
          3'd2:    sel = code_i;
          default: sel = SLAVE_ADDR;
        endcase
      end
      TXK_RD: begin
        case (idx_i)
          3'd1:    sel = func_i;
          3'd2:    sel = byte_count(data_i[6:0]);
          3'd3:    sel = rdat_i[15:8];
          3'd4:    sel = rdat_i[7:0];
          default: sel = SLAVE_ADDR;
        endcase
      end
      TXK_ECHO: begin
        case (idx_i)
          3'd1:    sel = func_i;
          3'd2:    sel = addr_i[15:8];
          3'd3:    sel = addr_i[7:0];
          3'd4:    sel = data_i[15:8];
          3'd5:    sel = data_i[7:0];
          default: sel = SLAVE_ADDR;
        endcase
      end
      default: sel = SLAVE_ADDR;
    endcase
  end

  assign acc_o = vld_q && tx_ready_i;

  // A pending byte is never replaced: load only lands once the slot is empty.
  always_comb begin
    vld_d  = vld_q;
    last_d = last_q;
    byte_d = byte_q;
    if (load_i && !vld_q) begin
      vld_d  = 1'b1;
      byte_d = sel;
      last_d = last_i;
    end else if (acc_o) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      byte_q <= 8'h00;
    end else begin
      vld_q  <= vld_d;
      last_q <= last_d;
      byte_q <= byte_d;
    end
  end

  assign tx_valid_o = vld_q;
  assign tx_byte_o  = byte_q;
  assign tx_last_o  = last_q;

endmodule

// File: rtl/modbus_req_ctrl.sv
// Modbus RTU request controller: takes one parsed request, asks the exception
// checker for a verdict, performs the register read(s)/write and streams the
// response payload (address..data, no CRC) to the TX frame builder.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   bus          modbus_req_ctrl_if.slave: rx_*, chk_*, reg_*, tx_*, busy,
//                frame_drop, chk_timeout
// Parameters:
//   SLAVE_ADDR   own station address
//   CHK_TIMEOUT  cycles CHECK waits for chk_done before aborting
// Build option:
//   MODBUS_BROADCAST_EN  accept station address 00; only 06 writes act on it,
//                        and no response is ever transmitted for it.
module modbus_req_ctrl
  import modbus_pkg::*;
#(
  parameter logic [7:0] SLAVE_ADDR  = 8'h01,
  parameter int         CHK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  modbus_req_ctrl_if.slave  bus
);

  localparam logic [7:0] TMO_LAST = 8'(CHK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  func_q, func_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  code_q, code_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] reg_i_q, reg_i_d;   // register currently being read
  logic [2:0]  idx_q, idx_d;       // byte index within the response
  logic [15:0] rdat_q, rdat_d;
  logic        bcast_q, bcast_d;
  logic        drop_q, drop_d;
  logic        tmo_q, tmo_d;

  logic        is_bcast, addr_ok;
  logic        tx_load, tx_last_in, tx_acc;
  logic        tx_valid, tx_last;
  logic [7:0]  tx_byte;
  tx_kind_e    tx_kind;

`ifdef MODBUS_BROADCAST_EN
  assign is_bcast = (bus.rx_slave == 8'h00);
`else
  assign is_bcast = 1'b0;
`endif
  assign addr_ok = (bus.rx_slave == SLAVE_ADDR) || is_bcast;

  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    addr_d  = addr_q;
    data_d  = data_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    reg_i_d = reg_i_q;
    idx_d   = idx_q;
    rdat_d  = rdat_q;
    bcast_d = bcast_q;
    tmo_d   = 1'b0;
    drop_d  = bus.rx_done && (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (bus.rx_done && addr_ok) begin
          func_d  = bus.rx_func;
          addr_d  = bus.rx_addr;
          data_d  = bus.rx_data;
          cnt_d   = 8'd0;
          bcast_d = is_bcast;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        cnt_d = cnt_q + 8'd1;
        // A verdict in the expiry cycle still counts, so chk_done is tested first.
        if (bus.chk_done) begin
          code_d  = bus.chk_code;
          reg_i_d = 16'd0;
          idx_d   = 3'd0;
          if (bcast_q)
            state_d = (bus.chk_code == EXC_NONE && func_q == FC_WR_SINGLE) ? S_WR : S_IDLE;
          else if (bus.chk_code != EXC_NONE)
            state_d = S_EXC_TX;
          else if (func_q == FC_RD_HOLD || func_q == FC_RD_IN)
            state_d = (data_q == 16'd0) ? S_RD_TX : S_RD_REQ;
          else if (func_q == FC_WR_SINGLE)
            state_d = S_WR;
          else
            state_d = S_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RD_REQ:  state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        rdat_d  = bus.reg_rd_data;
        state_d = S_RD_TX;
      end
      S_RD_TX: begin
        if (tx_acc) begin
          if (tx_last) begin
            state_d = S_IDLE;
          end else if (idx_q == 3'd4) begin
            // Lo byte sent; fetch the next register and resume at its hi byte.
            idx_d   = 3'd3;
            reg_i_d = reg_i_q + 16'd1;
            state_d = S_RD_REQ;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_WR: begin
        idx_d   = 3'd0;
        state_d = bcast_q ? S_IDLE : S_ECHO_TX;
      end
      S_EXC_TX, S_ECHO_TX: begin
        if (tx_acc) begin
          if (tx_last) state_d = S_IDLE;
          else         idx_d   = idx_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      func_q  <= 8'h00;
      addr_q  <= 16'h0000;
      data_q  <= 16'h0000;
      code_q  <= 8'h00;
      cnt_q   <= 8'h00;
      reg_i_q <= 16'h0000;
      idx_q   <= 3'd0;
      rdat_q  <= 16'h0000;
      bcast_q <= 1'b0;
      drop_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      reg_i_q <= reg_i_d;
      idx_q   <= idx_d;
      rdat_q  <= rdat_d;
      bcast_q <= bcast_d;
      drop_q  <= drop_d;
      tmo_q   <= tmo_d;
    end
  end

  // Frame kind and last-byte flag for the byte about to be loaded.
  always_comb begin
    tx_kind    = TXK_RD;
    tx_last_in = 1'b0;
    tx_load    = 1'b0;
    unique case (state_q)
      S_EXC_TX: begin
        tx_kind    = TXK_EXC;
        tx_last_in = (idx_q == 3'd2);
        tx_load    = !tx_valid;
      end
      S_ECHO_TX: begin
        tx_kind    = TXK_ECHO;
        tx_last_in = (idx_q == 3'd5);
        tx_load    = !tx_valid;
      end
      S_RD_TX: begin
        tx_kind    = TXK_RD;
        tx_last_in = (data_q == 16'd0) ? (idx_q == 3'd2)
                                       : (idx_q == 3'd4 && reg_i_q == data_q - 16'd1);
        tx_load    = !tx_valid;
      end
      default: ;
    endcase
  end

  modbus_tx_seq #(.SLAVE_ADDR(SLAVE_ADDR)) u_tx_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tx_load),
    .kind_i     (tx_kind),
    .idx_i      (idx_q),
    .last_i     (tx_last_in),
    .func_i     (func_q),
    .code_i     (code_q),
    .addr_i     (addr_q),
    .data_i     (data_q),
    .rdat_i     (rdat_q),
    .tx_ready_i (bus.tx_ready),
    .tx_valid_o (tx_valid),
    .tx_byte_o  (tx_byte),
    .tx_last_o  (tx_last),
    .acc_o      (tx_acc)
  );

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.chk_req     = (state_q == S_CHECK) && (cnt_q == 8'd0);
  assign bus.chk_func    = func_q;
  assign bus.chk_addr    = addr_q;
  assign bus.chk_data    = data_q;
  assign bus.reg_rd_en   = (state_q == S_RD_REQ);
  assign bus.reg_rd_addr = addr_q + reg_i_q;
  assign bus.reg_wr_en   = (state_q == S_WR);
  assign bus.reg_wr_addr = addr_q;
  assign bus.reg_wr_data = data_q;
  assign bus.tx_valid    = tx_valid;
  assign bus.tx_byte     = tx_byte;
  assign bus.tx_last     = tx_last;
  assign bus.frame_drop  = drop_q;
  assign bus.chk_timeout = tmo_q;

endmodule

// File: tb/tb_modbus_req_ctrl.sv
// Directed bench for modbus_req_ctrl: plays RX parser, exception checker,
// register file and TX builder; compares against hand-computed frames.
module tb_modbus_req_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  modbus_req_ctrl_if bus();

  modbus_req_ctrl #(.SLAVE_ADDR(8'h01), .CHK_TIMEOUT(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // register file contents
  function automatic logic [15:0] rf(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h0F0F;
      16'h0001: return 16'h1234;
      16'h0002: return 16'hABCD;
      16'h0003: return 16'h5A5A;
      16'hFFFF: return 16'hBEEF;
      default:  return 16'h0000;
    endcase
  endfunction

  always @(posedge clk)
    if (bus.reg_rd_en) bus.reg_rd_data <= rf(bus.reg_rd_addr);

  // monitor
  logic [7:0]  got_b[$];
  logic        got_l[$];
  logic [15:0] rd_a[$];
  int          rd_n = 0, wr_n = 0, last_n = 0, stalls = 0, hold_err = 0;
  logic [15:0] wr_a = '0, wr_d = '0;
  logic        hold_pend = 1'b0, hold_l = 1'b0;
  logic [7:0]  hold_b = '0;

  always @(posedge clk) begin
    if (bus.tx_valid && bus.tx_ready) begin
      got_b.push_back(bus.tx_byte);
      got_l.push_back(bus.tx_last);
      if (bus.tx_last) last_n <= last_n + 1;
    end
    if (bus.reg_rd_en) begin
      rd_a.push_back(bus.reg_rd_addr);
      rd_n <= rd_n + 1;
    end
    if (bus.reg_wr_en) begin
      wr_n <= wr_n + 1;
      wr_a <= bus.reg_wr_addr;
      wr_d <= bus.reg_wr_data;
    end
    if (hold_pend && rst_n &&
        !(bus.tx_valid && bus.tx_byte == hold_b && bus.tx_last == hold_l))
      hold_err <= hold_err + 1;
    hold_pend <= rst_n && bus.tx_valid && !bus.tx_ready;
    hold_b    <= bus.tx_byte;
    hold_l    <= bus.tx_last;
    if (bus.tx_valid && !bus.tx_ready) stalls <= stalls + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] sl, input logic [7:0] fn,
                         input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.rx_slave = sl; bus.rx_func = fn; bus.rx_addr = a; bus.rx_data = d;
    bus.rx_done  = 1'b1;
    @(negedge clk);
    bus.rx_done  = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int i = 0;
    while (!bus.chk_req && i < 20) begin @(negedge clk); i++; end
    chk({tag, " chk_req"}, bus.chk_req, 1);
  endtask

  task automatic verdict(input logic [7:0] code);
    bus.chk_done = 1'b1; bus.chk_code = code;
    @(negedge clk);
    bus.chk_done = 1'b0;
  endtask

  task automatic run_frame(input bit stall, input string tag);
    int t = 0, ph = 0;
    int l0 = last_n;
    while (last_n == l0 && t < 400) begin
      if (stall) begin bus.tx_ready = (ph == 0 || ph == 3); ph = (ph + 1) % 4; end
      else bus.tx_ready = 1'b1;
      @(negedge clk); t++;
    end
    bus.tx_ready = 1'b1;
    chk({tag, " done"}, (last_n != l0), 1);
    chk({tag, " idle"}, bus.busy, 0);
  endtask

  task automatic check_frame(input string tag, input int n, input logic [63:0] v);
    chk({tag, " len"}, got_b.size(), n);
    for (int k = 0; k < n; k++)
      if (k < got_b.size()) begin
        chk($sformatf("%s b%0d", tag, k), got_b[k], v[8*(n-1-k) +: 8]);
        chk($sformatf("%s l%0d", tag, k), got_l[k], (k == n-1));
      end
  endtask

  int rd0, wr0, st0, h0;

  task automatic req(input logic [7:0] fn, input logic [15:0] a, input logic [15:0] d,
                     input logic [7:0] code, input bit stall, input string tag);
    got_b.delete(); got_l.delete(); rd_a.delete();
    rd0 = rd_n; wr0 = wr_n; st0 = stalls; h0 = hold_err;
    send_rx(8'h01, fn, a, d);
    wait_req(tag);
    verdict(code);
    run_frame(stall, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  t;
    logic fd;
    bus.rx_done = 0; bus.rx_slave = 0; bus.rx_func = 0; bus.rx_addr = 0; bus.rx_data = 0;
    bus.chk_done = 0; bus.chk_code = 0; bus.tx_ready = 1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst busy",        bus.busy, 0);
    chk("rst tx_valid",    bus.tx_valid, 0);
    chk("rst chk_req",     bus.chk_req, 0);
    chk("rst chk_addr",    bus.chk_addr, 0);
    chk("rst chk_data",    bus.chk_data, 0);
    chk("rst rd_en",       bus.reg_rd_en, 0);
    chk("rst wr_en",       bus.reg_wr_en, 0);
    chk("rst chk_timeout", bus.chk_timeout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // foreign address ignored
    send_rx(8'h02, 8'h03, 16'h0001, 16'h0001);
    chk("foreign busy", bus.busy, 0);
    chk("foreign drop", bus.frame_drop, 0);
`ifndef MODBUS_BROADCAST_EN
    send_rx(8'h00, 8'h06, 16'h0001, 16'h0055);
    chk("bcast ignored", bus.busy, 0);
`else
    wr0 = wr_n; got_b.delete(); got_l.delete();
    send_rx(8'h00, 8'h06, 16'h0001, 16'h0055);
    wait_req("bcast");
    verdict(8'h00);
    repeat (4) @(negedge clk);
    chk("bcast wr", wr_n - wr0, 1);
    chk("bcast no tx", got_b.size(), 0);
    chk("bcast idle", bus.busy, 0);
`endif

    // 1: read one holding register
    req(8'h03, 16'h0001, 16'h0001, 8'h00, 1'b0, "t1");
    check_frame("t1", 5, 64'h01_03_02_12_34);
    chk("t1 rd cnt", rd_n - rd0, 1);
    if (rd_a.size() > 0) chk("t1 rd addr", rd_a[0], 16'h0001);
    chk("t1 wr cnt", wr_n - wr0, 0);

    // 2 + 5: read two input registers with tx_ready pattern 1-0-0-1
    req(8'h04, 16'h0002, 16'h0002, 8'h00, 1'b1, "t2");
    check_frame("t2", 7, 64'h01_04_04_AB_CD_5A_5A);
    chk("t2 rd cnt", rd_a.size(), 2);
    if (rd_a.size() > 1) begin
      chk("t2 rd addr0", rd_a[0], 16'h0002);
      chk("t2 rd addr1", rd_a[1], 16'h0003);
    end
    chk("t2 stalled", (stalls != st0), 1);
    chk("t5 hold", hold_err - h0, 0);

    // 3: exception verdict
    req(8'h05, 16'h0000, 16'h0000, 8'h01, 1'b0, "t3");
    check_frame("t3", 3, 64'h01_85_01);
    chk("t3 rd cnt", rd_n - rd0, 0);
    chk("t3 wr cnt", wr_n - wr0, 0);

    // 4: write single register
    req(8'h06, 16'h0001, 16'h0010, 8'h00, 1'b0, "t4");
    check_frame("t4", 6, 64'h01_06_00_01_00_10);
    chk("t4 wr cnt", wr_n - wr0, 1);
    chk("t4 wr addr", wr_a, 16'h0001);
    chk("t4 wr data", wr_d, 16'h0010);

    // quantity 0: header only
    req(8'h03, 16'h0005, 16'h0000, 8'h00, 1'b0, "tq0");
    check_frame("tq0", 3, 64'h01_03_00);
    chk("tq0 rd cnt", rd_n - rd0, 0);

    // address wraps at 16 bits
    req(8'h03, 16'hFFFF, 16'h0002, 8'h00, 1'b0, "twrap");
    check_frame("twrap", 7, 64'h01_03_04_BE_EF_0F_0F);
    if (rd_a.size() > 1) chk("twrap rd addr1", rd_a[1], 16'h0000);

    // 6: checker timeout, plus rx_done while busy
    got_b.delete(); got_l.delete();
    send_rx(8'h01, 8'h03, 16'h0001, 16'h0001);
    wait_req("t6");
    t = 0; fd = 1'b0;
    while (!bus.chk_timeout && t < 400) begin
      @(negedge clk); t++;
      if (t == 10) begin bus.rx_func = 8'h04; bus.rx_done = 1'b1; end
      if (t == 11) begin bus.rx_done = 1'b0; fd = bus.frame_drop; end
    end
    chk("t6 timeout cycle", t, 255);
    chk("t6 frame_drop", fd, 1);
    chk("t6 idle", bus.busy, 0);
    chk("t6 func kept", bus.chk_func, 8'h03);
    @(negedge clk);
    chk("t6 pulse", bus.chk_timeout, 0);
    chk("t6 no tx", got_b.size(), 0);

    // chk_done in the expiry cycle wins over timeout
    got_b.delete(); got_l.delete();
    send_rx(8'h01, 8'h03, 16'h0001, 16'h0001);
    wait_req("t7");
    repeat (254) @(negedge clk);
    verdict(8'h02);
    chk("t7 no timeout", bus.chk_timeout, 0);
    chk("t7 busy", bus.busy, 1);
    run_frame(1'b0, "t7");
    check_frame("t7", 3, 64'h01_83_02);

    // reset during a stalled TX byte
    got_b.delete(); got_l.delete();
    bus.tx_ready = 1'b0;
    send_rx(8'h01, 8'h03, 16'h0001, 16'h0001);
    wait_req("t8");
    verdict(8'h00);
    repeat (4) @(negedge clk);
    chk("t8 stalled valid", bus.tx_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t8 rst valid", bus.tx_valid, 0);
    chk("t8 rst busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1; bus.tx_ready = 1'b1;
    chk("t8 no tx", got_b.size(), 0);

    // reset during CHECK of a write: no write may be issued
    wr0 = wr_n;
    send_rx(8'h01, 8'h06, 16'h0001, 16'h0077);
    wait_req("t9");
    rst_n = 1'b0;
    verdict(8'h00);
    chk("t9 chk_addr", bus.chk_addr, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t9 no write", wr_n - wr0, 0);
    chk("t9 idle", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
